nrzi_deser_rx: RTL and testbench

- Receive end of the team's bit-serial link. The transmit side serializes words LSB-first, NRZI-encodes them, and drives them through an inverting line stage.
- This block undoes the inversion, NRZI-decodes the line, hunts for a sync word, and deserializes a fixed-length frame into parallel words.
- Words are presented on a valid/ready output toward the core logic.

---
 rtl/nrzi_pkg.sv | 18 +
 rtl/nrzi_bit_decoder.sv | 31 +++
 rtl/nrzi_deser_rx.sv | 134 +++++++++++++
 tb/tb_nrzi_deser_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nrzi_pkg.sv
// Shared types, defaults and width helpers for the NRZI serial receiver.
package nrzi_pkg;

  // Receiver frame state: hunting for sync, or collecting frame data.
  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_e;

  // Default sync pattern for an 8-bit link.
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Bits needed for a counter that must be able to hold the value w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nrzi_bit_decoder.sv
// Line conditioning and NRZI decode: one decoded bit per bit strobe.
module nrzi_bit_decoder #(
  parameter bit INVERT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  input  logic bit_en_i,
  output logic dbit_c_o,
  output logic dstb_c_o
);

  logic lvl_c;
  logic prev_q;

  assign lvl_c = line_i ^ INVERT;

  // Remember the level seen at the previous strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (bit_en_i) begin
      prev_q <= lvl_c;
    end
  end

  // No transition means a 1, a transition means a 0.
  assign dbit_c_o = (lvl_c == prev_q);
  assign dstb_c_o = bit_en_i;

endmodule

// File: rtl/nrzi_deser_rx.sv
// NRZI receiver: sync hunt, fixed-length frame deserialization, valid/ready output.
module nrzi_deser_rx
  import nrzi_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      FRAME_WORDS = 4,
  parameter bit               INVERT      = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(SYNC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_i,
  input  logic             bit_en_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             sync_o,
  output logic             in_frame_o,
  output logic             overrun_o
);

  localparam int unsigned CW  = cnt_width(WIDTH);
  localparam int unsigned WCW = 8;

  logic             dec_bit_c;
  logic             dec_stb_c;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    hunt_cnt_q;
  logic [CW-1:0]    hunt_cnt_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [WCW-1:0]   word_cnt_q;
  logic [WCW-1:0]   word_cnt_d;
  logic [WIDTH-1:0] m_data_q;
  logic             m_valid_q;
  logic             sync_q;
  logic             in_frame_q;
  logic             overrun_q;

  logic             word_done_c;
  logic             out_free_c;
  logic             retire_c;
  logic             sync_hit_c;
  logic             frame_end_c;

  nrzi_bit_decoder #(
    .INVERT (INVERT)
  ) u_dec (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .bit_en_i (bit_en_i),
    .dbit_c_o (dec_bit_c),
    .dstb_c_o (dec_stb_c)
  );

  // Next values of the shift register and counters for the current strobe.
  always_comb begin
    shift_d     = {dec_bit_c, shift_q[WIDTH-1:1]};
    hunt_cnt_d  = (hunt_cnt_q == CW'(WIDTH)) ? hunt_cnt_q : hunt_cnt_q + CW'(1);
    word_cnt_d  = word_cnt_q + WCW'(1);
    word_done_c = (bit_cnt_q == CW'(WIDTH - 1));
    retire_c    = m_valid_q & m_ready_i;
    out_free_c  = ~m_valid_q | m_ready_i;
    sync_hit_c  = (hunt_cnt_d == CW'(WIDTH)) && (shift_d == SYNC_WORD);
    frame_end_c = (word_cnt_d == WCW'(FRAME_WORDS));
  end

  // Frame FSM, deserializer and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      shift_q    <= '0;
      hunt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      sync_q     <= 1'b0;
      in_frame_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q <= 1'b0;
      if (retire_c) begin
        m_valid_q <= 1'b0;
      end
      if (dec_stb_c) begin
        shift_q <= shift_d;
        case (state_q)
          HUNT: begin
            hunt_cnt_q <= hunt_cnt_d;
            if (sync_hit_c) begin
              sync_q     <= 1'b1;
              state_q    <= DATA;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              in_frame_q <= 1'b1;
            end
          end
          DATA: begin
            if (word_done_c) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= word_cnt_d;
              // Load overrides retirement so back-to-back words keep valid high.
              if (out_free_c) begin
                m_data_q  <= shift_d;
                m_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              if (frame_end_c) begin
                state_q    <= HUNT;
                in_frame_q <= 1'b0;
                hunt_cnt_q <= '0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign m_data_o   = m_data_q;
  assign m_valid_o  = m_valid_q;
  assign sync_o     = sync_q;
  assign in_frame_o = in_frame_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_nrzi_deser_rx.sv
// Directed bench for nrzi_deser_rx with a bench-side NRZI encoder and inverting line.
module tb_nrzi_deser_rx;
  import nrzi_pkg::*;

  logic       clk;
  logic       rst;
  logic       line_i;
  logic       bit_en_i;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       sync_o;
  logic       in_frame_o;
  logic       overrun_o;

  int   passed = 0;
  int   total  = 0;
  int   nfail  = 0;
  int   sync_cnt = 0;
  int   sync_base;
  logic enc_lvl;
  logic last_dbit;

  nrzi_deser_rx #(
    .WIDTH       (8),
    .FRAME_WORDS (4),
    .INVERT      (1'b1),
    .SYNC_WORD   (8'hA5)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .line_i     (line_i),
    .bit_en_i   (bit_en_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .sync_o     (sync_o),
    .in_frame_o (in_frame_o),
    .overrun_o  (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count sync pulses, sampled away from the rising edge.
  always @(negedge clk) begin
    if (sync_o) sync_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // NRZI-encode one bit, drive it inverted for a single strobe cycle.
  task automatic send_bit(input logic b);
    if (!b) enc_lvl = ~enc_lvl;
    line_i   = enc_lvl ^ 1'b1;
    bit_en_i = 1'b1;
    #1;
    last_dbit = u_dut.dec_bit_c;
    @(posedge clk); #1;
    bit_en_i = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bit_en_i = 1'b0;
    @(posedge clk); #1;
    rst     = 1'b0;
    enc_lvl = 1'b0;
  endtask

  initial begin
    logic [7:0] w2;
    rst       = 1'b1;
    line_i    = 1'b1;
    bit_en_i  = 1'b0;
    m_ready_i = 1'b0;
    enc_lvl   = 1'b0;
    last_dbit = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state
    check("rst_data", 32'(m_data_o), 32'h0);
    check("rst_valid", 32'(m_valid_o), 32'h0);
    check("rst_sync", 32'(sync_o), 32'h0);
    check("rst_inframe", 32'(in_frame_o), 32'h0);
    check("rst_overrun", 32'(overrun_o), 32'h0);
    check("rst_state", 32'(u_dut.state_q), 32'(HUNT));

    // NRZI decode with a strobe every third cycle
    send_bit(1'b1); check("dec0", 32'(last_dbit), 32'h1); idle(2);
    send_bit(1'b1); check("dec1", 32'(last_dbit), 32'h1); idle(2);
    send_bit(1'b0); check("dec2", 32'(last_dbit), 32'h0); idle(2);
    send_bit(1'b0); check("dec3", 32'(last_dbit), 32'h0); idle(2);
    send_bit(1'b1); check("dec4", 32'(last_dbit), 32'h1); idle(2);
    check("dec_valid", 32'(m_valid_o), 32'h0);
    check("dec_inframe", 32'(in_frame_o), 32'h0);
    check("dec_nosync", 32'(sync_cnt), 32'h0);

    // Sync plus one frame with ready held high
    do_reset();
    m_ready_i = 1'b1;
    sync_base = sync_cnt;
    send_word(8'hA5);
    check("sync_pulse", 32'(sync_o), 32'h1);
    check("sync_inframe", 32'(in_frame_o), 32'h1);
    idle(1);
    check("sync_one_cycle", 32'(sync_o), 32'h0);
    send_word(8'h3C);
    check("f_w0_valid", 32'(m_valid_o), 32'h1);
    check("f_w0_data", 32'(m_data_o), 32'h3C);
    send_word(8'h00);
    check("f_w1_valid", 32'(m_valid_o), 32'h1);
    check("f_w1_data", 32'(m_data_o), 32'h00);
    send_word(8'hFF);
    check("f_w2_data", 32'(m_data_o), 32'hFF);
    check("f_w2_inframe", 32'(in_frame_o), 32'h1);
    send_word(8'h81);
    check("f_w3_valid", 32'(m_valid_o), 32'h1);
    check("f_w3_data", 32'(m_data_o), 32'h81);
    check("f_inframe_drop", 32'(in_frame_o), 32'h0);
    idle(1);
    check("f_retired", 32'(m_valid_o), 32'h0);
    check("f_sync_count", 32'(sync_cnt - sync_base), 32'h1);

    // Re-entered hunt: leftover MSB would complete 0xA5 after only 7 new bits
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle(1);
    check("rehunt_nosync", 32'(sync_cnt - sync_base), 32'h1);
    check("rehunt_inframe", 32'(in_frame_o), 32'h0);

    // Short/false sync after reset
    do_reset();
    sync_base = sync_cnt;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    idle(1);
    check("false_nosync", 32'(sync_cnt - sync_base), 32'h0);
    check("false_valid", 32'(m_valid_o), 32'h0);
    check("false_inframe", 32'(in_frame_o), 32'h0);

    // Backpressure: ready low for the whole frame
    do_reset();
    m_ready_i = 1'b0;
    send_word(8'hA5);
    send_word(8'h3C);
    check("bp_w0_valid", 32'(m_valid_o), 32'h1);
    check("bp_w0_data", 32'(m_data_o), 32'h3C);
    check("bp_w0_overrun", 32'(overrun_o), 32'h0);
    send_word(8'h00);
    check("bp_w1_overrun", 32'(overrun_o), 32'h1);
    check("bp_w1_data", 32'(m_data_o), 32'h3C);
    send_word(8'hFF);
    send_word(8'h81);
    check("bp_w3_data", 32'(m_data_o), 32'h3C);
    check("bp_w3_inframe", 32'(in_frame_o), 32'h0);
    idle(3);
    check("bp_sticky", 32'(overrun_o), 32'h1);
    m_ready_i = 1'b1;
    idle(1);
    check("bp_retire", 32'(m_valid_o), 32'h0);
    check("bp_sticky2", 32'(overrun_o), 32'h1);
    do_reset();
    check("bp_rst_overrun", 32'(overrun_o), 32'h0);

    // Retire and load on the same edge
    m_ready_i = 1'b0;
    send_word(8'hA5);
    send_word(8'h3C);
    w2 = 8'h00;
    for (int i = 0; i < 7; i++) send_bit(w2[i]);
    check("rl_hold_data", 32'(m_data_o), 32'h3C);
    check("rl_hold_valid", 32'(m_valid_o), 32'h1);
    m_ready_i = 1'b1;
    send_bit(w2[7]);
    check("rl_valid", 32'(m_valid_o), 32'h1);
    check("rl_data", 32'(m_data_o), 32'h00);
    check("rl_overrun", 32'(overrun_o), 32'h0);
    idle(1);
    check("rl_retired", 32'(m_valid_o), 32'h0);
    send_word(8'hFF);
    send_word(8'h81);
    check("rl_last_data", 32'(m_data_o), 32'h81);
    check("rl_overrun_end", 32'(overrun_o), 32'h0);

    // Reset in the middle of word 2, then a clean frame
    do_reset();
    m_ready_i = 1'b1;
    send_word(8'hA5);
    send_word(8'h3C);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_reset();
    check("mr_data", 32'(m_data_o), 32'h0);
    check("mr_valid", 32'(m_valid_o), 32'h0);
    check("mr_inframe", 32'(in_frame_o), 32'h0);
    check("mr_sync", 32'(sync_o), 32'h0);
    check("mr_state", 32'(u_dut.state_q), 32'(HUNT));
    sync_base = sync_cnt;
    send_word(8'hA5);
    send_word(8'h3C);
    check("mr_w0", 32'(m_data_o), 32'h3C);
    send_word(8'h00);
    check("mr_w1", 32'(m_data_o), 32'h00);
    send_word(8'hFF);
    check("mr_w2", 32'(m_data_o), 32'hFF);
    send_word(8'h81);
    check("mr_w3", 32'(m_data_o), 32'h81);
    check("mr_w3_valid", 32'(m_valid_o), 32'h1);
    check("mr_inframe_end", 32'(in_frame_o), 32'h0);
    idle(1);
    check("mr_sync_count", 32'(sync_cnt - sync_base), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
